// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl: generates the CPU clock-enable from a programmable divider.
// Modes are idle, free run, and single step. A halt request from the CPU parks
// the controller until the mode is returned to idle.
//
// Optional feature macro: CPU_CLK_CTRL_CYCLE_CNT_EN
//   When defined, cycle_count counts the cpu_clk_en pulses issued.
//   When undefined, there is no counter and cycle_count is tied to zero.
//
// Ports:
//   clk_1M      in   system clock; all logic runs on its rising edge
//   reset       in   synchronous, active-high reset
//   mode[1:0]   in   00 idle, 01 run, 10 step, 11 idle
//   step_btn    in   debounced single-step button level
//   halt_req    in   CPU halt request level (HLT executed)
//   div_load    in   one-cycle strobe that loads div_value
//   div_value   in   new divider value; tick period is div_value+1 cycles
//   div_ack     out  one-cycle pulse confirming a divider load
//   cpu_clk_en  out  one-cycle CPU clock-enable pulse
//   state[1:0]  out  00 IDLE, 01 RUN, 10 STEP_WAIT, 11 HALTED
//   cycle_count out  number of cpu_clk_en pulses issued (wraps)
module cpu_clk_ctrl #(
  parameter logic [31:0] DIV_RESET = 32'd499
) (
  input  logic        clk_1M,
  input  logic        reset,
  input  logic [1:0]  mode,
  input  logic        step_btn,
  input  logic        halt_req,
  input  logic        div_load,
  input  logic [31:0] div_value,
  output logic        div_ack,
  output logic        cpu_clk_en,
  output logic [1:0]  state,
  output logic [31:0] cycle_count
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'b00,
    S_RUN       = 2'b01,
    S_STEP_WAIT = 2'b10,
    S_HALTED    = 2'b11
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        pulse_c;
  logic [31:0] div_reg;
  logic [31:0] cnt;
  logic        btn_q;
  logic        tick_c;
  logic        step_rise_c;

  // A divider load takes priority over a tick in the same cycle.
  assign tick_c      = (cnt == div_reg) && !div_load;
  assign step_rise_c = step_btn && !btn_q;
  assign state       = state_q;

  // Free-running divider. It runs in every state so step and run timing stay
  // aligned to the divider. The >= comparison keeps cnt bounded by div_reg.
  always_ff @(posedge clk_1M) begin
    if (reset) begin
      div_reg <= DIV_RESET;
      cnt     <= 32'd0;
      div_ack <= 1'b0;
    end else begin
      div_ack <= div_load;
      if (div_load) begin
        div_reg <= div_value;
        cnt     <= 32'd0;
      end else if (cnt >= div_reg) begin
        cnt <= 32'd0;
      end else begin
        cnt <= cnt + 32'd1;
      end
    end
  end

  // State register, registered clock-enable, and step button edge detect.
  always_ff @(posedge clk_1M) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cpu_clk_en <= 1'b0;
      btn_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cpu_clk_en <= pulse_c;
      btn_q      <= step_btn;
    end
  end

  // Next-state and pulse qualification. Halt always wins over a tick.
  always_comb begin
    state_d = state_q;
    pulse_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mode == 2'b01) begin
          state_d = S_RUN;
        end else if ((mode == 2'b10) && step_rise_c) begin
          state_d = S_STEP_WAIT;
        end
      end
      S_RUN: begin
        if (halt_req) begin
          state_d = S_HALTED;
        end else begin
          pulse_c = tick_c;
          if (mode != 2'b01) begin
            state_d = S_IDLE;
          end
        end
      end
      S_STEP_WAIT: begin
        // Further button edges are ignored here; the first tick ends the step.
        if (halt_req) begin
          state_d = S_HALTED;
        end else if (tick_c) begin
          pulse_c = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_HALTED: begin
        if ((mode == 2'b00) || (mode == 2'b11)) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef CPU_CLK_CTRL_CYCLE_CNT_EN
  // Counts on the qualified pulse so the count moves together with cpu_clk_en.
  always_ff @(posedge clk_1M) begin
    if (reset) begin
      cycle_count <= 32'd0;
    end else if (pulse_c) begin
      cycle_count <= cycle_count + 32'd1;
    end
  end
`else
  assign cycle_count = 32'd0;
`endif

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Scoreboard bench for cpu_clk_ctrl. The stimulus pushes the expected pulses
// and acks, each with the cycle it should appear in. The monitor pops and
// compares them whenever the DUT raises cpu_clk_en or div_ack.
module tb_cpu_clk_ctrl;

`ifdef CPU_CLK_CTRL_CYCLE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk_1M;
  logic        reset;
  logic [1:0]  mode;
  logic        step_btn;
  logic        halt_req;
  logic        div_load;
  logic [31:0] div_value;
  logic        div_ack;
  logic        cpu_clk_en;
  logic [1:0]  state;
  logic [31:0] cycle_count;

  cpu_clk_ctrl #(.DIV_RESET(32'd3)) dut (
    .clk_1M     (clk_1M),
    .reset      (reset),
    .mode       (mode),
    .step_btn   (step_btn),
    .halt_req   (halt_req),
    .div_load   (div_load),
    .div_value  (div_value),
    .div_ack    (div_ack),
    .cpu_clk_en (cpu_clk_en),
    .state      (state),
    .cycle_count(cycle_count)
  );

  typedef struct {
    logic [31:0] at;
    logic [31:0] cnt;
  } pulse_t;

  pulse_t      pq[$];
  logic [31:0] aq[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] cyc = 32'd0;
  pulse_t      mp;
  logic [31:0] ma;

  initial clk_1M = 1'b0;
  always #5 clk_1M = ~clk_1M;
  always @(posedge clk_1M) cyc <= cyc + 32'd1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input int unsigned n);
    return CNT_EN ? 32'(n) : 32'd0;
  endfunction

  task automatic push_pulse(input logic [31:0] at, input int unsigned n);
    pulse_t p;
    p.at  = at;
    p.cnt = exp_cnt(n);
    pq.push_back(p);
  endtask

  // Each call advances to 1 time unit after the rising edge that makes cyc == t.
  task automatic goto(input logic [31:0] t);
    while (cyc < t) begin
      @(posedge clk_1M);
      #1;
    end
  endtask

  task automatic do_reset(output logic [31:0] b);
    reset = 1'b1; mode = 2'b00; step_btn = 1'b0; halt_req = 1'b0;
    div_load = 1'b0; div_value = 32'd0;
    goto(cyc + 32'd2);
    reset = 1'b0;
    b = cyc;
  endtask

  // Monitor: compare every pulse and every ack against the scoreboard.
  always @(negedge clk_1M) begin
    if (cpu_clk_en) begin
      if (pq.size() == 0) begin
        chk("unexpected_pulse_at_cycle", cyc, 32'hFFFF_FFFF);
      end else begin
        mp = pq.pop_front();
        chk("pulse_cycle", cyc, mp.at);
        chk("pulse_cycle_count", cycle_count, mp.cnt);
      end
    end
    if (div_ack) begin
      if (aq.size() == 0) begin
        chk("unexpected_ack_at_cycle", cyc, 32'hFFFF_FFFF);
      end else begin
        ma = aq.pop_front();
        chk("ack_cycle", cyc, ma);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] b;
    logic [31:0] b2;

    // Reset values.
    do_reset(b);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_clk_en", 32'(cpu_clk_en), 32'd0);
    chk("rst_div_ack", 32'(div_ack), 32'd0);
    chk("rst_cycle_count", cycle_count, 32'd0);

    // Run mode with divider 3: a pulse every 4 cycles, 5 pulses in 20 cycles.
    do_reset(b);
    mode = 2'b01;
    for (int k = 1; k <= 5; k++) push_pulse(b + 32'(4 * k), k);
    goto(b + 32'd21);
    chk("run_cycle_count", cycle_count, exp_cnt(5));
    chk("run_state", 32'(state), 32'd1);
    chk("run_pending", 32'(pq.size()), 32'd0);

    // Single step: one pulse per button edge; holding the button gives no repeat.
    do_reset(b);
    mode = 2'b10;
    goto(b + 32'd1);
    step_btn = 1'b1;
    push_pulse(b + 32'd4, 1);
    goto(b + 32'd6);
    chk("step_back_idle", 32'(state), 32'd0);
    goto(b + 32'd16);
    step_btn = 1'b0;
    goto(b + 32'd17);
    step_btn = 1'b1;
    push_pulse(b + 32'd20, 2);
    goto(b + 32'd18);
    chk("step_wait_state", 32'(state), 32'd2);
    goto(b + 32'd21);
    chk("step_end_state", 32'(state), 32'd0);
    chk("step_pending", 32'(pq.size()), 32'd0);

    // Divider reload to 0 (a pulse every cycle), then a reload that collides with a tick.
    do_reset(b);
    mode = 2'b01;
    push_pulse(b + 32'd4, 1);
    push_pulse(b + 32'd8, 2);
    goto(b + 32'd9);
    div_load = 1'b1; div_value = 32'd0;
    aq.push_back(b + 32'd10);
    goto(b + 32'd10);
    div_load = 1'b0;
    for (int k = 0; k < 10; k++) push_pulse(b + 32'(11 + k), 3 + k);
    goto(b + 32'd20);
    div_load = 1'b1; div_value = 32'd2;
    aq.push_back(b + 32'd21);
    goto(b + 32'd21);
    div_load = 1'b0;
    push_pulse(b + 32'd24, 13);
    push_pulse(b + 32'd27, 14);
    push_pulse(b + 32'd30, 15);
    goto(b + 32'd31);
    chk("div_cycle_count", cycle_count, exp_cnt(15));
    chk("div_pending", 32'(pq.size() + aq.size()), 32'd0);

    // Halt request on a tick cycle: no pulse, stay halted until the mode returns to idle.
    do_reset(b);
    mode = 2'b01;
    push_pulse(b + 32'd4, 1);
    goto(b + 32'd7);
    halt_req = 1'b1;
    goto(b + 32'd8);
    halt_req = 1'b0;
    chk("halt_state", 32'(state), 32'd3);
    goto(b + 32'd14);
    chk("halt_hold_state", 32'(state), 32'd3);
    mode = 2'b00;
    goto(b + 32'd15);
    chk("halt_exit_state", 32'(state), 32'd0);
    chk("halt_cycle_count", cycle_count, exp_cnt(1));
    chk("halt_pending", 32'(pq.size()), 32'd0);

    // Reset mid-count with a same-cycle div_load: the load is discarded.
    do_reset(b);
    mode = 2'b01;
    push_pulse(b + 32'd4, 1);
    goto(b + 32'd6);
    reset = 1'b1; div_load = 1'b1; div_value = 32'd7;
    goto(b + 32'd7);
    chk("rst2_state", 32'(state), 32'd0);
    chk("rst2_clk_en", 32'(cpu_clk_en), 32'd0);
    chk("rst2_div_ack", 32'(div_ack), 32'd0);
    chk("rst2_cycle_count", cycle_count, 32'd0);
    reset = 1'b0; div_load = 1'b0;
    b2 = cyc;
    push_pulse(b2 + 32'd4, 1);
    push_pulse(b2 + 32'd8, 2);
    goto(b2 + 32'd9);
    chk("rst2_pending", 32'(pq.size() + aq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_clk_ctrl.md
CPU_CLK_CTRL -- requirements
Module: cpu_clk_ctrl

Interface
REQ-001 Parameter DIV_RESET, default 32'd499, divider value loaded at reset (tick period DIV_RESET+1 cycles).
REQ-002 clk_1M  input  1  system clock; all logic on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 mode  input  2  00 IDLE, 01 RUN, 10 STEP, 11 treated as IDLE.
REQ-005 step_btn  input  1  debounced single-step button level.
REQ-006 halt_req  input  1  CPU halt request (HLT executed), level.
REQ-007 div_load  input  1  one-cycle strobe: load div_value.
REQ-008 div_value  input  32  new divider value.
REQ-009 div_ack  output  1  one-cycle pulse confirming a divider load.
REQ-010 cpu_clk_en  output  1  one-cycle CPU clock-enable pulse.
REQ-011 state  output  2  FSM state: 00 IDLE, 01 RUN, 10 STEP_WAIT, 11 HALTED.
REQ-012 cycle_count  output  32  number of cpu_clk_en pulses issued.

Function
REQ-013 Internal div_reg (32b) and cnt (32b); cnt counts 0..div_reg, wraps to 0; tick is true in the cycle cnt==div_reg.
REQ-014 div_value=0 SHALL give tick every cycle; cnt SHALL never exceed div_reg.
REQ-015 div_load: next cycle div_reg=div_value, cnt=0, div_ack=1 for one cycle; takes priority over a same-cycle tick (no pulse that cycle).
REQ-016 cpu_clk_en is registered: asserted the cycle after a qualifying tick, for exactly one cycle.
REQ-017 IDLE: no pulses; mode=01 -> RUN; mode=10 -> STEP_WAIT only on step_btn rising edge (registered edge detect).
REQ-018 RUN: every tick qualifies; mode!=01 -> IDLE; halt_req=1 -> HALTED.
REQ-019 STEP_WAIT: first tick after entry qualifies, then -> IDLE; further step_btn edges while in STEP_WAIT are ignored; halt_req -> HALTED without pulse.
REQ-020 HALTED: no pulses; leaves only when mode=00 or 11 (-> IDLE), regardless of halt_req.
REQ-021 halt_req and tick in same cycle: pulse suppressed, -> HALTED.
REQ-022 cycle_count increments by 1 per cpu_clk_en pulse, wraps 32'hFFFFFFFF -> 0.
REQ-023 cnt keeps free-running in every state so step/run timing stays aligned to the divider.

Reset
REQ-024 On reset: state=IDLE, cnt=0, div_reg=DIV_RESET, cpu_clk_en=0, div_ack=0, cycle_count=0, edge-detect register=0.
REQ-025 Reset overrides all inputs, including a same-cycle div_load; a pending step or pulse is discarded.

Configuration
REQ-026 Macro CPU_CLK_CTRL_CYCLE_CNT_EN: defined -> cycle_count counter implemented per REQ-022; undefined -> no counter, cycle_count tied to 32'd0; all other behaviour identical.

Verification
REQ-027 Reset, DIV_RESET=3, mode=01 for 20 cycles -> cpu_clk_en pulses every 4 cycles, 5 pulses, cycle_count=5 (macro defined).
REQ-028 mode=10, one step_btn press, div 3 -> exactly one pulse within 5 cycles, state back to 00; holding step_btn high -> no second pulse.
REQ-029 RUN, div_load with div_value=0 -> div_ack next cycle, then cpu_clk_en every cycle.
REQ-030 RUN, halt_req asserted on tick cycle -> no pulse, state=11; mode=01 kept -> stays 11; mode=00 -> state 00.
REQ-031 RUN with reset asserted mid-count and div_load same cycle -> div_reg=DIV_RESET, all outputs 0, state 00.
REQ-032 Macro undefined, 10 RUN pulses -> cycle_count stays 0.
